// File: rtl/rf_wb_queue_if.sv
// rf_wb_queue_if: write-request, RF write-port, forwarding and status bundle for rf_wb_queue
interface rf_wb_queue_if #(
  parameter int DATAWIDTH = 64,
  parameter int ADDRW = 2,
  parameter int DEPTH = 4
);
  localparam int PW = $clog2(DEPTH) + 1;
  logic in_valid;
  logic in_ready;
  logic [ADDRW-1:0] in_addr;
  logic [DATAWIDTH-1:0] in_data;
  logic drain_en;
  logic rf_wen;
  logic [ADDRW-1:0] rf_waddr;
  logic [DATAWIDTH-1:0] rf_wdata;
  logic [ADDRW-1:0] fwd_raddr1;
  logic [ADDRW-1:0] fwd_raddr2;
  logic fwd_hit1;
  logic fwd_hit2;
  logic [DATAWIDTH-1:0] fwd_data1;
  logic [DATAWIDTH-1:0] fwd_data2;
  logic [PW-1:0] count;
  logic full;
  logic empty;
  modport master (
    output in_valid, in_addr, in_data, drain_en, fwd_raddr1, fwd_raddr2,
    input in_ready, rf_wen, rf_waddr, rf_wdata, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count, full, empty
  );
  modport slave (
    input in_valid, in_addr, in_data, drain_en, fwd_raddr1, fwd_raddr2,
    output in_ready, rf_wen, rf_waddr, rf_wdata, fwd_hit1, fwd_hit2, fwd_data1, fwd_data2, count, full, empty
  );
endinterface

// File: rtl/rf_wb_queue.sv
// rf_wb_queue: in-order RF write-back queue (clk, active-low sync rst; q: in_* enqueue, rf_* drain, fwd_* youngest-entry forwarding, count/full/empty)
module rf_wb_queue #(
  parameter int DATAWIDTH = 64,
  parameter int ADDRW = 2,
  parameter int DEPTH = 4
) (
  input logic clk,
  input logic rst,
  rf_wb_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [ADDRW-1:0] addr_q [DEPTH];
  logic [DATAWIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, cnt;
  logic full, empty, push, pop, hit1, hit2;
  logic [DATAWIDTH-1:0] fd1, fd2;
  logic [AW-1:0] slot;
  assign cnt = wr_ptr_q - rd_ptr_q;
  assign full = cnt == PW'(DEPTH);
  assign empty = cnt == '0;
  assign push = q.in_valid && !full;
  assign pop = q.drain_en && !empty;
  assign q.in_ready = !full;
  assign q.rf_wen = pop;
  assign q.rf_waddr = addr_q[rd_ptr_q[AW-1:0]];
  assign q.rf_wdata = data_q[rd_ptr_q[AW-1:0]];
  assign q.count = cnt;
  assign q.full = full;
  assign q.empty = empty;
  assign q.fwd_hit1 = hit1;
  assign q.fwd_hit2 = hit2;
  assign q.fwd_data1 = fd1;
  assign q.fwd_data2 = fd2;
  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
  end
  always_ff @(posedge clk) begin
    wr_ptr_q <= !rst ? '0 : wr_ptr_d;
    rd_ptr_q <= !rst ? '0 : rd_ptr_d;
  end
  always_ff @(posedge clk)
    if (push) begin
      addr_q[wr_ptr_q[AW-1:0]] <= q.in_addr;
      data_q[wr_ptr_q[AW-1:0]] <= q.in_data;
    end
  // scan oldest to youngest so the last match left standing is the newest write
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    fd1 = '0;
    fd2 = '0;
    slot = '0;
    for (int i = 0; i < DEPTH; i++) begin
      slot = rd_ptr_q[AW-1:0] + AW'(i);
      if (PW'(i) < cnt && addr_q[slot] == q.fwd_raddr1) begin
        hit1 = 1'b1;
        fd1 = data_q[slot];
      end
      if (PW'(i) < cnt && addr_q[slot] == q.fwd_raddr2) begin
        hit2 = 1'b1;
        fd2 = data_q[slot];
      end
    end
  end
endmodule

// File: tb/tb_rf_wb_queue.sv
// tb_rf_wb_queue: scoreboard bench for rf_wb_queue against a queue-based reference model
module tb_rf_wb_queue;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int fails = 0;
  bit mon_en = 1'b0;
  logic [65:0] model[$];
  logic [65:0] exp_wr[$];
  rf_wb_queue_if #(.DATAWIDTH(64), .ADDRW(2), .DEPTH(4)) q ();
  rf_wb_queue #(.DATAWIDTH(64), .ADDRW(2), .DEPTH(4)) dut (.clk(clk), .rst(rst), .q(q));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic enq(input logic [1:0] a, input logic [63:0] d, output int n);
    bit acc;
    acc = 1'b0;
    n = 0;
    q.in_valid = 1'b1;
    q.in_addr = a;
    q.in_data = d;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = q.in_ready;
      @(posedge clk);
      n++;
      if (acc) exp_wr.push_back({a, d});
    end
    #1 q.in_valid = 1'b0;
    chk("enq_accept", 64'(acc), 64'd1);
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  initial begin
    int sz;
    logic eh1, eh2;
    logic [63:0] ed1, ed2;
    logic [65:0] e;
    forever begin
      @(negedge clk);
      sz = model.size();
      if (mon_en) begin
        chk("count", 64'(q.count), 64'(sz));
        chk("full", 64'(q.full), 64'(sz == 4));
        chk("empty", 64'(q.empty), 64'(sz == 0));
        chk("in_ready", 64'(q.in_ready), 64'(sz < 4));
        chk("rf_wen", 64'(q.rf_wen), 64'(q.drain_en && sz > 0));
        eh1 = 1'b0;
        eh2 = 1'b0;
        ed1 = '0;
        ed2 = '0;
        foreach (model[i]) begin
          if (model[i][65:64] == q.fwd_raddr1) begin
            eh1 = 1'b1;
            ed1 = model[i][63:0];
          end
          if (model[i][65:64] == q.fwd_raddr2) begin
            eh2 = 1'b1;
            ed2 = model[i][63:0];
          end
        end
        chk("fwd_hit1", 64'(q.fwd_hit1), 64'(eh1));
        chk("fwd_hit2", 64'(q.fwd_hit2), 64'(eh2));
        chk("fwd_data1", q.fwd_data1, ed1);
        chk("fwd_data2", q.fwd_data2, ed2);
        if (q.rf_wen) begin
          if (exp_wr.size() == 0) begin
            checks++;
            fails++;
            $display("FAIL rf_unexpected: got write %0h=%0h expected none at %0t", q.rf_waddr, q.rf_wdata, $time);
          end else begin
            e = exp_wr.pop_front();
            chk("rf_waddr", 64'(q.rf_waddr), 64'(e[65:64]));
            chk("rf_wdata", q.rf_wdata, e[63:0]);
          end
        end
      end
      if (!rst) begin
        model.delete();
        exp_wr.delete();
      end else begin
        if (q.drain_en && sz > 0) void'(model.pop_front());
        if (q.in_valid && sz < 4) model.push_back({q.in_addr, q.in_data});
      end
    end
  end
  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    q.in_valid = 1'b0;
    q.in_addr = '0;
    q.in_data = '0;
    q.drain_en = 1'b0;
    q.fwd_raddr1 = '0;
    q.fwd_raddr2 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    mon_en = 1'b1;
    #2;
    chk("rst_count", 64'(q.count), 64'd0);
    chk("rst_empty", 64'(q.empty), 64'd1);
    chk("rst_in_ready", 64'(q.in_ready), 64'd1);
    chk("rst_rf_wen", 64'(q.rf_wen), 64'd0);
    for (int a = 0; a < 4; a++) begin
      q.fwd_raddr1 = 2'(a);
      q.fwd_raddr2 = 2'(3 - a);
      #1;
      chk("rst_hit1", 64'(q.fwd_hit1), 64'd0);
      chk("rst_hit2", 64'(q.fwd_hit2), 64'd0);
    end
    tick(1);
    enq(2'd1, 64'hA, n);
    enq(2'd2, 64'hB, n);
    enq(2'd3, 64'hC, n);
    enq(2'd0, 64'hD, n);
    #2;
    chk("fill_full", 64'(q.full), 64'd1);
    chk("fill_in_ready", 64'(q.in_ready), 64'd0);
    chk("fill_count", 64'(q.count), 64'd4);
    q.drain_en = 1'b1;
    enq(2'd2, 64'hE, n);
    chk("held_wait", 64'(n), 64'd2);
    tick(6);
    chk("drain_empty", 64'(q.empty), 64'd1);
    q.drain_en = 1'b0;
    enq(2'd2, 64'h11, n);
    enq(2'd2, 64'h22, n);
    q.fwd_raddr1 = 2'd2;
    q.fwd_raddr2 = 2'd3;
    #2;
    chk("fy_hit1", 64'(q.fwd_hit1), 64'd1);
    chk("fy_data1", q.fwd_data1, 64'h22);
    chk("fy_hit2", 64'(q.fwd_hit2), 64'd0);
    chk("fy_data2", q.fwd_data2, 64'd0);
    q.drain_en = 1'b1;
    @(posedge clk);
    #1 q.drain_en = 1'b0;
    #2;
    chk("fy1_hit1", 64'(q.fwd_hit1), 64'd1);
    chk("fy1_data1", q.fwd_data1, 64'h22);
    q.drain_en = 1'b1;
    @(posedge clk);
    #1 q.drain_en = 1'b0;
    #2;
    chk("fy2_hit1", 64'(q.fwd_hit1), 64'd0);
    chk("fy2_data1", q.fwd_data1, 64'd0);
    q.drain_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      q.fwd_raddr1 = 2'($urandom_range(3, 0));
      enq(2'(i % 4), 64'(i), n);
      chk("stream_wait", 64'(n), 64'd1);
    end
    tick(2);
    for (int r = 0; r < 10; r++) begin
      q.drain_en = 1'b0;
      for (int k = 0; k < 4; k++) begin
        q.fwd_raddr1 = 2'($urandom_range(3, 0));
        q.fwd_raddr2 = 2'($urandom_range(3, 0));
        enq(2'($urandom_range(3, 0)), {$urandom, $urandom}, n);
      end
      #2;
      chk("wrap_full", 64'(q.full), 64'd1);
      q.drain_en = 1'b1;
      tick(4);
      #1;
      chk("wrap_empty", 64'(q.empty), 64'd1);
      chk("wrap_count", 64'(q.count), 64'd0);
    end
    q.drain_en = 1'b0;
    enq(2'd0, 64'h1, n);
    enq(2'd1, 64'h2, n);
    enq(2'd3, 64'h3, n);
    q.fwd_raddr1 = 2'd1;
    q.fwd_raddr2 = 2'd3;
    q.drain_en = 1'b1;
    rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("mrst_count", 64'(q.count), 64'd0);
    chk("mrst_rf_wen", 64'(q.rf_wen), 64'd0);
    chk("mrst_hit1", 64'(q.fwd_hit1), 64'd0);
    chk("mrst_hit2", 64'(q.fwd_hit2), 64'd0);
    enq(2'd1, 64'h55, n);
    tick(3);
    chk("sb_drained", 64'(exp_wr.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/rf_wb_queue.md
# rf_wb_queue

Write-back queue between the execute/load stages and the register file write port. Buffers up to DEPTH register write requests and drains them in order, one per cycle, onto the RF's single write port (wen/waddr/wdata). Provides read-address forwarding so the RF read stage can observe queued-but-not-yet-written data. The newest queued write to an address always wins.

## Interface
- DATAWIDTH, 64, width of register data; matches RF DATAWIDTH.
- ADDRW, 2, register address width; matches RF address width.
- DEPTH, 4, queue entries; power of two, ≥2.

- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-low: state clears on a rising clk edge while rst=0.
- in_valid  in  1  write request present.
- in_ready  out  1  queue can accept; equals !full.
- in_addr  in  ADDRW  destination register.
- in_data  in  DATAWIDTH  value to write.
- drain_en  in  1  permission to issue the head entry to the RF this cycle.
- rf_wen  out  1  to RF wen.
- rf_waddr  out  ADDRW  to RF waddr.
- rf_wdata  out  DATAWIDTH  to RF wdata.
- fwd_raddr1, fwd_raddr2  in  ADDRW  same addresses presented to the RF raddr1/raddr2.
- fwd_hit1, fwd_hit2  out  1  a queued entry targets the matching raddr.
- fwd_data1, fwd_data2  out  DATAWIDTH  newest queued data for that raddr; 0 when no hit.
- count  out  log2(DEPTH)+1  occupied entries.
- full, empty  out  1  count==DEPTH / count==0.

## Operation
- Circular buffer: addr/data arrays of DEPTH entries; wr_ptr and rd_ptr are log2(DEPTH)+1 bits wide. The MSB distinguishes full from empty. Pointers wrap modulo 2·DEPTH.
- Enqueue: in_valid && in_ready at a rising edge writes {in_addr, in_data} at wr_ptr and increments wr_ptr.
- Dequeue: rf_wen = !empty && drain_en, combinational. rf_waddr/rf_wdata present the head entry at rd_ptr. When rf_wen=1 at a rising edge, rd_ptr increments; the RF captures the data on the same edge.
- rf_waddr/rf_wdata are don't-care when rf_wen=0. The bench checks them only when rf_wen=1.
- count = wr_ptr − rd_ptr (mod 2·DEPTH). It updates +1 on enqueue only, −1 on dequeue only, and is unchanged on simultaneous enqueue+dequeue.
- Full: in_ready=0 even if a dequeue occurs in the same cycle; no enqueue-on-full pass-through. Requests with in_valid=1 and in_ready=0 are held by the producer, not dropped.
- Forwarding (combinational, per read port):
  - Scan only occupied entries, rd_ptr up to wr_ptr−1, including the head being drained this cycle.
  - hit = any entry with addr==fwd_raddrN.
  - data = the matching entry closest to wr_ptr (youngest).
  - A request on in_* in the current cycle is not visible to forwarding until after it is enqueued.
- Consumer usage: operand = fwd_hitN ? fwd_dataN : RF rdataN.
- Ordering: writes reach the RF in exact enqueue order; multiple writes to one address are all issued.
- No overflow/underflow state possible; no error outputs.

## Timing
- Reset (rst=0 at edge): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, in_ready=1, rf_wen=0, fwd_hit1/2=0, fwd_data1/2=0.
- Array contents are not reset; their validity is derived from the pointers only.
- Reset mid-operation discards all queued entries. rf_wen is forced 0 in the cycle after the reset edge. No write issued in the reset cycle is guaranteed.
- Latency: request enqueued at edge N can drive rf_wen=1 in cycle N→N+1 and be written to the RF at edge N+1 (if drain_en=1).
- Throughput: 1 enqueue + 1 dequeue per cycle sustained; with drain_en held 1 the queue never exceeds 1 entry.
- Forward outputs settle combinationally from pointer/array state and fwd_raddr within the same cycle.
- in_ready depends only on registered state; it has no combinational path from in_valid or drain_en.

## Test plan
- Reset/idle: hold rst=0 two cycles, then release → count=0, empty=1, in_ready=1, rf_wen=0, fwd_hit=0 for all addresses.
- Fill/drain:
  - drain_en=0; enqueue (1,0xA),(2,0xB),(3,0xC),(0,0xD) → full=1, in_ready=0, count=4.
  - Fifth request held; drain_en=1 → rf_wen for 4 cycles, addrs 1,2,3,0 with data A,B,C,D in order.
  - Held request accepted in the cycle after the first dequeue.
- Forward youngest: drain_en=0; enqueue (2,0x11),(2,0x22); fwd_raddr1=2, fwd_raddr2=3 → hit1=1 data1=0x22, hit2=0 data2=0.
  - Drain one entry → still 0x22. Drain second → hit1=0.
- Streaming: drain_en=1, back-to-back in_valid for 20 cycles with (i mod 4, i) → every write appears on rf_* exactly one cycle after its enqueue, count≤1, in_ready stays 1.
- Wrap-around: 10 fill-to-full / drain-to-empty rounds of random data → RF-side sequence equals enqueue sequence; full/empty correct at each pointer wrap.
- Reset mid-operation: 3 entries queued, rst=0 for one edge while drain_en=1 → after the edge count=0, rf_wen=0, fwd_hit=0. The next enqueue (1,0x55) drains as the first write.
